// File: rtl/dmem_rr_arbiter.sv
`timescale 1ns/1ps
// dmem_rr_arbiter
// Shares one data-memory port between NUM_REQ requesters using a round-robin
// pointer. Each transaction takes IDLE (accept) -> ACCESS (memory cycle) ->
// RESP (hold response until the owner takes it). Misaligned or out-of-range
// addresses never reach the memory and come back with rsp_err set.
module dmem_rr_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int DEPTH_WORDS = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_we,
    input  logic [32*NUM_REQ-1:0]  req_addr,
    input  logic [32*NUM_REQ-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     rsp_valid,
    input  logic [NUM_REQ-1:0]     rsp_ready,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [31:0]            mem_addr,
    output logic [31:0]            mem_wdata,
    input  logic [31:0]            mem_rdata,
    output logic                   busy
);

    localparam int PW = (NUM_REQ > 2) ? 2 : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

    // An access is refused when it is not word aligned or falls past the array.
    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= ADDR_LIMIT);
    endfunction

    // Index following the given owner, wrapping at NUM_REQ.
    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] cur);
        logic [PW-1:0] res;
        if (cur == PW'(NUM_REQ - 1)) begin
            res = '0;
        end else begin
            res = cur + PW'(1);
        end
        return res;
    endfunction

    logic [1:0]    state_r;
    logic [PW-1:0] ptr_r;
    logic [PW-1:0] owner_r;
    logic          we_r;
    logic [31:0]   addr_r;
    logic [31:0]   wdata_r;
    logic [31:0]   rdata_r;
    logic          err_r;

    logic          grant_found_s;
    logic [PW-1:0] grant_idx_s;
    int            dist_s;
    int            best_dist_s;
    logic          acc_err_s;

    // Pick the valid requester closest to ptr going upward with wrap-around.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        best_dist_s   = NUM_REQ;
        dist_s        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            dist_s = i - int'(ptr_r);
            if (dist_s < 0) begin
                dist_s = dist_s + NUM_REQ;
            end else begin
                dist_s = dist_s;
            end
            if (req_valid[i] && (dist_s < best_dist_s)) begin
                best_dist_s   = dist_s;
                grant_found_s = 1'b1;
                grant_idx_s   = PW'(i);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Accept strobe: only the winner, only while idle and not being reset.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if ((state_r == ST_IDLE) && !rst && grant_found_s &&
                (grant_idx_s == PW'(i))) begin
                req_ready[i] = 1'b1;
            end else begin
                req_ready[i] = 1'b0;
            end
        end
    end

    // Memory strobes exist only in ACCESS and only for a legal address.
    always_comb begin
        acc_err_s = addr_bad(addr_r);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = 32'h0000_0000;
        mem_wdata = 32'h0000_0000;
        if ((state_r == ST_ACCESS) && !acc_err_s) begin
            mem_read  = !we_r;
            mem_write = we_r;
            mem_addr  = addr_r;
            mem_wdata = wdata_r;
        end else begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
    end

    // Response strobe goes to the latched owner while in RESP.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if ((state_r == ST_RESP) && (owner_r == PW'(i))) begin
                rsp_valid[i] = 1'b1;
            end else begin
                rsp_valid[i] = 1'b0;
            end
        end
    end

    assign busy      = (state_r != ST_IDLE);
    assign rsp_rdata = rdata_r;
    assign rsp_err   = err_r;

    // Transaction FSM with latched request copy and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            ptr_r   <= '0;
            owner_r <= '0;
            we_r    <= 1'b0;
            addr_r  <= 32'h0000_0000;
            wdata_r <= 32'h0000_0000;
            rdata_r <= 32'h0000_0000;
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_found_s) begin
                        owner_r <= grant_idx_s;
                        we_r    <= req_we[grant_idx_s];
                        addr_r  <= req_addr[32*grant_idx_s +: 32];
                        wdata_r <= req_wdata[32*grant_idx_s +: 32];
                        state_r <= ST_ACCESS;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    rdata_r <= (!acc_err_s && !we_r) ? mem_rdata : 32'h0000_0000;
                    err_r   <= acc_err_s;
                    state_r <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready[owner_r]) begin
                        ptr_r   <= next_idx(owner_r);
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
